// File: rtl/mult_pkg.sv
// mult_pkg: shared defaults and tag record for the round-robin multiplier scheduler
package mult_pkg;
  localparam int WIDTH_DEF = 4;
  localparam int LATENCY_DEF = 2;
  localparam int ID_MAXW = 4;
  typedef struct packed {
    logic v;
    logic [ID_MAXW-1:0] id;
  } tag_t;
endpackage

// File: rtl/mult_rr_grant.sv
// rr_grant: combinational round-robin priority encoder; req/ptr/en in, one-hot gnt and encoded gnt_id out
module rr_grant #(
  parameter int NREQ = 4,
  parameter int IDW = 2
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  ptr,
  input  logic            en,
  output logic [NREQ-1:0] gnt,
  output logic [IDW-1:0]  gnt_id
);
  int j;
  logic found;
  always_comb begin
    gnt = '0;
    gnt_id = '0;
    found = 1'b0;
    j = 0;
    for (int k = 0; k < NREQ; k++) begin
      j = (int'(ptr) + k) % NREQ;
      if (en && req[j] && !found) begin
        gnt[j] = 1'b1;
        gnt_id = IDW'(j);
        found = 1'b1;
      end
    end
  end
endmodule

// File: rtl/multiplier.sv
// multiplier: unsigned pipelined multiplier (input regs + output regs, LATENCY>=2); ports clk, a, b -> y
module multiplier #(
  parameter int WIDTH = 4,
  parameter int LATENCY = 2
) (
  input  logic               clk,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  output logic [2*WIDTH-1:0] y
);
  logic [WIDTH-1:0] a_q, b_q;
  logic [2*WIDTH-1:0] p [LATENCY-1];
  always_ff @(posedge clk) begin
    a_q <= a;
    b_q <= b;
    p[0] <= {{WIDTH{1'b0}}, a_q} * {{WIDTH{1'b0}}, b_q};
    for (int k = 1; k < LATENCY - 1; k++) p[k] <= p[k-1];
  end
  assign y = p[LATENCY-2];
endmodule

// File: rtl/mult_rr_sched.sv
// mult_rr_sched: shares one pipelined multiplier among NREQ requesters; req_* handshake in, mul_* to multiplier, res_* result bus, busy
module mult_rr_sched
  import mult_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF,
  parameter int NREQ = 4,
  parameter int LATENCY = LATENCY_DEF,
  localparam int IDW = (NREQ > 1) ? $clog2(NREQ) : 1
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  en,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_a,
  input  logic [NREQ*WIDTH-1:0] req_b,
  output logic [NREQ-1:0]       req_ready,
  output logic [WIDTH-1:0]      mul_a,
  output logic [WIDTH-1:0]      mul_b,
  input  logic [2*WIDTH-1:0]    mul_y,
  output logic                  res_valid,
  output logic [IDW-1:0]        res_id,
  output logic [2*WIDTH-1:0]    res_y,
  output logic                  busy
);
  logic [IDW-1:0] rr_ptr, gnt_id;
  logic xfer;
  tag_t tags [LATENCY];
  rr_grant #(.NREQ(NREQ), .IDW(IDW)) u_grant (
    .req(req_valid),
    .ptr(rr_ptr),
    .en(en & rst_n),
    .gnt(req_ready),
    .gnt_id(gnt_id)
  );
  assign xfer = |req_ready;
  assign mul_a = xfer ? req_a[gnt_id*WIDTH +: WIDTH] : '0;
  assign mul_b = xfer ? req_b[gnt_id*WIDTH +: WIDTH] : '0;
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rr_ptr <= '0;
      for (int k = 0; k < LATENCY; k++) tags[k] <= '0;
    end else begin
      tags[0] <= '{v: xfer, id: ID_MAXW'(gnt_id)};
      for (int k = 1; k < LATENCY; k++) tags[k] <= tags[k-1];
      if (xfer) rr_ptr <= IDW'((int'(gnt_id) + 1) % NREQ);
    end
  end
  always_comb begin
    busy = 1'b0;
    for (int k = 0; k < LATENCY; k++) busy = busy | tags[k].v;
  end
  assign res_valid = tags[LATENCY-1].v;
  assign res_id = IDW'(tags[LATENCY-1].id);
  assign res_y = res_valid ? mul_y : '0;
endmodule

// File: tb/tb_mult_rr_sched.sv
// tb_mult_rr_sched: table-driven and randomized self-checking bench with a result scoreboard
module tb_mult_rr_sched;
  logic clk = 1'b0;
  logic rst_n, en;
  logic [3:0] req_valid, req_ready;
  logic [15:0] req_a, req_b;
  logic [3:0] mul_a, mul_b;
  logic [7:0] mul_y, res_y;
  logic res_valid, busy;
  logic [1:0] res_id;
  always #5 clk = ~clk;
  mult_rr_sched #(.WIDTH(4), .NREQ(4), .LATENCY(2)) dut (
    .clk(clk), .rst_n(rst_n), .en(en), .req_valid(req_valid), .req_a(req_a), .req_b(req_b),
    .req_ready(req_ready), .mul_a(mul_a), .mul_b(mul_b), .mul_y(mul_y),
    .res_valid(res_valid), .res_id(res_id), .res_y(res_y), .busy(busy)
  );
  multiplier #(.WIDTH(4), .LATENCY(2)) u_mul (.clk(clk), .a(mul_a), .b(mul_b), .y(mul_y));
  typedef struct {
    logic r;
    logic e;
    logic [3:0] v;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0] rdy;
  } vec_t;
  typedef struct {
    int id;
    int y;
    int due;
  } exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, edge_n = 0;
  task automatic chk(input string nm, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d (edge %0d)", nm, act, exp, edge_n);
    end
  endtask
  task automatic step(input vec_t t);
    int gid, ea, eb;
    logic ev;
    gid = -1;
    rst_n = t.r; en = t.e; req_valid = t.v; req_a = t.a; req_b = t.b;
    #1;
    chk("req_ready", int'(req_ready), int'(t.rdy));
    for (int i = 0; i < 4; i++) if (t.rdy[i]) gid = i;
    ea = gid >= 0 ? int'(t.a[gid*4 +: 4]) : 0;
    eb = gid >= 0 ? int'(t.b[gid*4 +: 4]) : 0;
    chk("mul_a", int'(mul_a), ea);
    chk("mul_b", int'(mul_b), eb);
    @(posedge clk);
    edge_n++;
    if (!t.r) q.delete();
    else if (gid >= 0) q.push_back('{gid, ea * eb, edge_n + 1});
    #1;
    ev = q.size() > 0 && q[0].due == edge_n;
    chk("res_valid", int'(res_valid), int'(ev));
    chk("busy", int'(busy), int'(q.size() > 0));
    chk("res_y", int'(res_y), ev ? q[0].y : 0);
    if (ev) begin
      chk("res_id", int'(res_id), q[0].id);
      void'(q.pop_front());
    end
  endtask
  vec_t tbl[$];
  initial begin
    vec_t t;
    int mptr, gid;
    tbl = '{
      '{1'b0, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h0},
      '{1'b0, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h0},
      '{1'b1, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h1},
      '{1'b1, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h2},
      '{1'b1, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h4},
      '{1'b1, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h8},
      '{1'b1, 1'b1, 4'hF, 16'h803F, 16'h2B4F, 4'h1},
      '{1'b1, 1'b1, 4'h4, 16'h0700, 16'h0900, 4'h4},
      '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0},
      '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0},
      '{1'b1, 1'b1, 4'h2, 16'hA5C3, 16'h1E7D, 4'h2},
      '{1'b1, 1'b1, 4'hA, 16'hA5C3, 16'h1E7D, 4'h8},
      '{1'b1, 1'b1, 4'hA, 16'hA5C3, 16'h1E7D, 4'h2},
      '{1'b1, 1'b1, 4'hB, 16'hA5C3, 16'h1E7D, 4'h8},
      '{1'b1, 1'b1, 4'hB, 16'hA5C3, 16'h1E7D, 4'h1},
      '{1'b1, 1'b1, 4'hF, 16'h6B9E, 16'h47DF, 4'h2},
      '{1'b1, 1'b1, 4'hF, 16'h6B9E, 16'h47DF, 4'h4},
      '{1'b1, 1'b0, 4'hF, 16'h6B9E, 16'h47DF, 4'h0},
      '{1'b1, 1'b0, 4'hF, 16'h6B9E, 16'h47DF, 4'h0},
      '{1'b1, 1'b0, 4'hF, 16'h6B9E, 16'h47DF, 4'h0},
      '{1'b1, 1'b1, 4'hF, 16'h6B9E, 16'h47DF, 4'h8},
      '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0},
      '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0},
      '{1'b1, 1'b1, 4'h1, 16'h0005, 16'h0005, 4'h1},
      '{1'b0, 1'b1, 4'hF, 16'h0005, 16'h0005, 4'h0},
      '{1'b1, 1'b1, 4'hF, 16'h0005, 16'h0005, 4'h1},
      '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0},
      '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0}
    };
    foreach (tbl[i]) step(tbl[i]);
    t = '{1'b0, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0};
    step(t);
    mptr = 0;
    for (int n = 0; n < 60; n++) begin
      t.r = 1'b1;
      t.e = $urandom_range(0, 7) != 0;
      t.v = 4'($urandom_range(0, 15));
      t.a = 16'($urandom);
      t.b = 16'($urandom);
      t.rdy = '0;
      gid = -1;
      for (int k = 0; k < 4; k++)
        if (gid < 0 && t.e && t.v[(mptr + k) % 4]) gid = (mptr + k) % 4;
      if (gid >= 0) begin
        t.rdy[gid] = 1'b1;
        mptr = (gid + 1) % 4;
      end
      step(t);
    end
    t = '{1'b1, 1'b1, 4'h0, 16'h0000, 16'h0000, 4'h0};
    step(t);
    step(t);
    chk("drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
